check_seq: RTL and testbench

Parametrised serial sequence detector: shifts in one data bit per enabled clock and compares the last W bits against a pattern. The pattern can be reloaded at run time. Overlapping or non-overlapping detection is selectable, and a saturating match counter is kept. It generalises the fixed 6-bit detector to any width and adds run-time pattern, enable, mode and counting.

---
 rtl/check_seq_if.sv | 36 +++
 rtl/check_seq.sv | 81 ++++++++
 tb/tb_check_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/check_seq_if.sv
// check_seq_if: bundles the serial-detector data/control inputs and the
// registered result outputs.
//   en      bit-valid strobe
//   d       serial data bit
//   ovl     1 = overlapping detection, 0 = non-overlapping
//   pat_ld  load pat_in into the pattern register
//   pat_in  new pattern value (W bits)
//   flag    registered one-cycle match pulse
//   q       shift window, q[0] is the newest bit
//   pat     current pattern register
//   cnt     saturating match count
// master drives the stimulus side; slave is the detector.
interface check_seq_if #(
  parameter int W  = 6,
  parameter int CW = 8
);
  logic          en;
  logic          d;
  logic          ovl;
  logic          pat_ld;
  logic [W-1:0]  pat_in;
  logic          flag;
  logic [W-1:0]  q;
  logic [W-1:0]  pat;
  logic [CW-1:0] cnt;

  modport master (
    output en, d, ovl, pat_ld, pat_in,
    input  flag, q, pat, cnt
  );

  modport slave (
    input  en, d, ovl, pat_ld, pat_in,
    output flag, q, pat, cnt
  );
endinterface

// File: rtl/check_seq.sv
// check_seq: parametrised serial sequence detector.
// One bit of d is shifted into the window q on every edge with en=1; the
// last W bits are compared against the run-time loadable pattern register.
// A fill counter makes sure W genuine bits have been received (since reset
// or since the last non-overlapping hit) before a match may be reported.
// Ports:
//   clk  rising-edge clock
//   r    synchronous active-high reset, overrides every other input
//   bus  check_seq_if.slave carrying en/d/ovl/pat_ld/pat_in in and
//        flag/q/pat/cnt out; all outputs are straight from registers.
module check_seq #(
  parameter int            W       = 6,
  parameter logic [W-1:0]  PATTERN = 6'b101011,
  parameter int            CW      = 8
) (
  input  logic        clk,
  input  logic        r,
  check_seq_if.slave  bus
);

  localparam int            FW   = $clog2(W + 1);
  localparam logic [FW-1:0] FULL = FW'(W);

  logic [W-1:0]  q_r;
  logic [W-1:0]  pat_r;
  logic [FW-1:0] fc;
  logic          flag_r;
  logic [CW-1:0] cnt_r;

  logic [W-1:0]  q_n;
  logic [FW-1:0] fc_n;
  logic          hit;

  // Next-window and match decision for the current edge. The comparison
  // uses the pattern register as it stands before any load on this edge.
  always_comb begin
    q_n  = {q_r[W-2:0], bus.d};
    fc_n = (fc == FULL) ? fc : fc + FW'(1);
    hit  = bus.en && (fc_n == FULL) && (q_n == pat_r);
  end

  // NOTE: every register here is written with <= so all updates on an edge
  // see the pre-edge values; mixing in = would make the result depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (r) begin
      q_r    <= '0;
      fc     <= '0;
      flag_r <= 1'b0;
      cnt_r  <= '0;
      pat_r  <= PATTERN;
    end else begin
      // flag is a one-cycle pulse: any edge that is not a hit clears it.
      flag_r <= hit;

      if (bus.pat_ld) begin
        pat_r <= bus.pat_in;
      end

      if (bus.en) begin
        q_r <= q_n;
        // A non-overlapping hit discards the matched bits for future
        // matches, although q keeps showing them.
        if (hit && !bus.ovl) begin
          fc <= '0;
        end else begin
          fc <= fc_n;
        end
        if (hit && (cnt_r != {CW{1'b1}})) begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign bus.flag = flag_r;
  assign bus.q    = q_r;
  assign bus.pat  = pat_r;
  assign bus.cnt  = cnt_r;

endmodule

// File: tb/tb_check_seq.sv
// Self-checking bench for check_seq. Two detectors share one stimulus
// stream: one with an 8-bit counter, one with a 2-bit counter so that
// saturation is reached quickly. A behavioural model (bit history queue
// plus a count of bits since the window was last cleared) predicts every
// output and is compared on each falling edge; directed scenarios add
// hand-computed literal expectations.
module tb_check_seq;

  localparam int           W   = 6;
  localparam logic [W-1:0] PAT = 6'b101011;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         en = 1'b0;
  logic         d = 1'b0;
  logic         ovl = 1'b1;
  logic         pat_ld = 1'b0;
  logic [W-1:0] pat_in = '0;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  check_seq_if #(.W(W), .CW(8)) b8 ();
  check_seq_if #(.W(W), .CW(2)) b2 ();

  assign b8.en = en;  assign b8.d = d;  assign b8.ovl = ovl;
  assign b8.pat_ld = pat_ld;  assign b8.pat_in = pat_in;
  assign b2.en = en;  assign b2.d = d;  assign b2.ovl = ovl;
  assign b2.pat_ld = pat_ld;  assign b2.pat_in = pat_in;

  check_seq #(.W(W), .PATTERN(PAT), .CW(8)) dut8 (.clk(clk), .r(r), .bus(b8));
  check_seq #(.W(W), .PATTERN(PAT), .CW(2)) dut2 (.clk(clk), .r(r), .bus(b2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           hist[$];
  int           since = 0;
  int           mcnt = 0;
  logic         mflag = 1'b0;
  logic [W-1:0] mpat = PAT;
  logic [W-1:0] mwin = '0;

  always @(posedge clk) begin
    if (r) begin
      hist.delete();
      since = 0;
      mcnt  = 0;
      mflag = 1'b0;
      mpat  = PAT;
      mwin  = '0;
    end else begin
      logic h;
      h = 1'b0;
      if (en) begin
        hist.push_back(d);
        if (hist.size() > W) void'(hist.pop_front());
        since++;
        mwin = '0;
        foreach (hist[i]) mwin = {mwin[W-2:0], hist[i]};
        h = (since >= W) && (mwin == mpat);
        if (h) begin
          mcnt++;
          if (!ovl) since = 0;
        end
      end
      mflag = h;
      if (pat_ld) mpat = pat_in;
    end
  end

  // Compare process: outputs are checked on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("flag",  b8.flag, mflag);
      check("q",     b8.q,    mwin);
      check("pat",   b8.pat,  mpat);
      check("cnt8",  b8.cnt,  (mcnt > 255) ? 255 : mcnt);
      check("flag2", b2.flag, mflag);
      check("cnt2",  b2.cnt,  (mcnt > 3) ? 3 : mcnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic e, input logic b);
    en = e;
    d  = b;
    @(posedge clk);
    @(negedge clk);
    #1;
    pat_ld = 1'b0;
    r      = 1'b0;
  endtask

  task automatic do_reset();
    r = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [10:0] s;
    logic [10:0] fl11;
    logic [7:0]  fl8;
    logic [5:0]  fl6;
    int          nflags;

    s = 11'b10101101011;

    do_reset();
    do_reset();
    chk_on = 1'b1;
    check("reset_q",   b8.q,    6'b0);
    check("reset_pat", b8.pat,  PAT);
    check("reset_cnt", b8.cnt,  8'd0);
    check("reset_flg", b8.flag, 1'b0);

    // Overlap, default pattern
    ovl = 1'b1;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      step(1'b1, s[i]);
      fl11[10-i] = b8.flag;
    end
    check("ovl_flags", fl11, 11'b10000100000);
    check("ovl_cnt",   b8.cnt, 8'd2);
    check("ovl_q",     b8.q,   6'b101011);

    // Non-overlap, same stream
    ovl = 1'b0;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      step(1'b1, s[i]);
      fl11[10-i] = b8.flag;
    end
    check("novl_flags", fl11, 11'b00000100000);
    check("novl_cnt",   b8.cnt, 8'd1);

    // Pattern reload on the edge of bit 1, then ones
    ovl = 1'b1;
    do_reset();
    pat_in = 6'h3F;
    pat_ld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      fl8[i] = b8.flag;
    end
    check("rld_ovl_flags", fl8, 8'b11100000);
    check("rld_ovl_cnt",   b8.cnt, 8'd3);

    ovl = 1'b0;
    do_reset();
    pat_in = 6'h3F;
    pat_ld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      fl8[i] = b8.flag;
    end
    check("rld_novl_flags", fl8, 8'b00100000);
    check("rld_novl_cnt",   b8.cnt, 8'd1);

    // Load on the completing edge still compares against the old pattern
    ovl = 1'b1;
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b1);
    pat_in = 6'b000000;
    pat_ld = 1'b1;
    step(1'b1, 1'b1);
    check("ldedge_flag", b8.flag, 1'b1);
    check("ldedge_pat",  b8.pat,  6'b000000);

    // Fill: all-zero pattern needs six real zeros
    do_reset();
    pat_in = 6'b000000;
    pat_ld = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      fl6[i] = b8.flag;
    end
    check("fill_flags", fl6, 6'b100000);

    // Reset mid-stream discards the partial window
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    r = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    check("rstmid_flag", b8.flag, 1'b0);
    check("rstmid_q",    b8.q,    6'b000011);
    check("rstmid_cnt",  b8.cnt,  8'd0);

    // Enable gaps between pattern bits
    do_reset();
    nflags = 0;
    for (int k = 5; k >= 0; k--) begin
      step(1'b1, PAT[k]);
      nflags += int'(b8.flag);
      if (k == 0) check("gap_flag_edge6", b8.flag, 1'b1);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, ~PAT[k]);
        nflags += int'(b8.flag);
      end
    end
    check("gap_nflags", nflags, 1);
    check("gap_q",      b8.q,   PAT);

    // Counter saturation on the 2-bit counter
    ovl = 1'b1;
    do_reset();
    pat_in = 6'h3F;
    pat_ld = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (i >= 6) begin
        check("sat_cnt2",  b2.cnt,  (i - 5 > 3) ? 2'd3 : 2'(i - 5));
        check("sat_flag2", b2.flag, 1'b1);
      end
    end
    check("sat_cnt8", b8.cnt, 8'd5);

    // Randomised phase against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ovl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) begin
        pat_ld = 1'b1;
        pat_in = ($urandom_range(0, 1) == 1) ? 6'h3F : W'($urandom);
      end
      if ($urandom_range(0, 199) == 0) r = 1'b1;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
